// File: rtl/wb_master_q_if.sv
// Bundle of CPU request/response and Wishbone signals for wb_master_q.
// Names keep the master's point of view: i_* flow into the master, o_* flow out of it.
interface wb_master_q_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req_valid;
    logic            o_req_ready;
    logic            i_req_we;
    logic [AW-1:0]   i_req_addr;
    logic [DW-1:0]   i_req_data;
    logic [DW/8-1:0] i_req_sel;

    logic            o_rsp_valid;
    logic            o_rsp_we;
    logic [DW-1:0]   o_rsp_data;
    logic            o_rsp_err;
    logic            o_busy;

    logic [AW-1:0]   o_wb_adr;
    logic [DW-1:0]   o_wb_dat;
    logic [DW/8-1:0] o_wb_sel;
    logic            o_wb_we;
    logic            o_wb_cyc;
    logic            o_wb_stb;
    logic [DW-1:0]   i_wb_dat;
    logic            i_wb_ack;
    logic            i_wb_err;

    modport master (
        input  i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_sel,
        input  i_wb_dat, i_wb_ack, i_wb_err,
        output o_req_ready, o_rsp_valid, o_rsp_we, o_rsp_data, o_rsp_err, o_busy,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_sel,
        output i_wb_dat, i_wb_ack, i_wb_err,
        input  o_req_ready, o_rsp_valid, o_rsp_we, o_rsp_data, o_rsp_err, o_busy,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );
endinterface

// File: rtl/wb_master_q.sv
// Queued Wishbone B4 classic master: requests wait in a DEPTH-entry FIFO and are
// issued one at a time, each closed by a one-cycle response pulse (ack, err or timeout).
module wb_master_q #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    wb_master_q_if.master bus
);
    localparam int SW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW:0]   FULL     = (PW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } req_t;

    req_t          mem_q [DEPTH];
    req_t          head;
    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_we_q, rsp_we_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          push, pop, tmo_fire;

    always_comb begin
        push        = bus.i_req_valid && (count_q < FULL);
        pop         = 1'b0;
        head        = mem_q[rd_ptr_q];
        tmo_fire    = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
        state_d     = state_q;
        tmo_d       = tmo_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    adr_d   = head.addr;
                    sel_d   = head.sel;
                    we_d    = head.we;
                    dat_d   = head.we ? head.data : '0;
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // err wins over a simultaneous ack; a timeout counts as an error too
                if (bus.i_wb_ack || bus.i_wb_err || tmo_fire) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_err_d   = bus.i_wb_err || !bus.i_wb_ack;
                    rsp_data_d  = (bus.i_wb_ack && !bus.i_wb_err && !we_q) ? bus.i_wb_dat : '0;
                    state_d     = IDLE;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.i_req_we, bus.i_req_addr, bus.i_req_data, bus.i_req_sel};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.o_req_ready = (count_q < FULL);
    assign bus.o_busy      = (count_q != '0) || (state_q == WAIT);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_we    = rsp_we_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_wb_adr    = adr_q;
    assign bus.o_wb_dat    = dat_q;
    assign bus.o_wb_sel    = sel_q;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = cyc_q;
endmodule

// File: tb/tb_wb_master_q.sv
// Bench for wb_master_q: a scripted Wishbone slave plus a transaction-level model of
// expected bus cycles, responses and cycle lengths; a second instance covers TIMEOUT=0.
module tb_wb_master_q;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    wb_master_q_if #(.AW(AW), .DW(DW)) bus ();
    wb_master_q_if #(.AW(AW), .DW(DW)) bus0 ();

    wb_master_q #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    wb_master_q #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(0)) dut0 (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus0)
    );

    txn_t        bus_q[$], exp_txn_q[$];
    rsp_t        rsp_q[$], exp_rsp_q[$];
    int          len_q[$], exp_len_q[$], gap_q[$];
    int          mode_q[$], lat_q[$];
    logic [31:0] rd_key;
    logic        spurious;
    int          stab_viol;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Slave modes: 0 ack, 1 err, 2 ack+err, 3 silent; lat = idle cycles before answering
    initial begin : slave
        bit active;
        int cur_lat;
        int cur_mode;
        int wcnt;
        active   = 1'b0;
        cur_lat  = 0;
        cur_mode = 0;
        wcnt     = 0;
        bus.i_wb_ack  = 1'b0;
        bus.i_wb_err  = 1'b0;
        bus.i_wb_dat  = '0;
        bus0.i_wb_ack = 1'b0;
        bus0.i_wb_err = 1'b0;
        bus0.i_wb_dat = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_wb_ack = 1'b0;
            bus.i_wb_err = 1'b0;
            bus.i_wb_dat = '0;
            if (rstn && bus.o_wb_cyc && bus.o_wb_stb) begin
                if (!active) begin
                    active   = 1'b1;
                    wcnt     = 0;
                    cur_lat  = 0;
                    cur_mode = 0;
                    if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
                    if (mode_q.size() > 0) cur_mode = mode_q.pop_front();
                end
                if (cur_mode != 3 && wcnt == cur_lat) begin
                    bus.i_wb_ack = (cur_mode == 0 || cur_mode == 2);
                    bus.i_wb_err = (cur_mode == 1 || cur_mode == 2);
                    bus.i_wb_dat = bus.o_wb_adr ^ rd_key;
                end
                wcnt++;
            end else begin
                active = 1'b0;
                bus.i_wb_ack = spurious;
            end
        end
    end

    initial begin : monitor
        bit   cyc_prev;
        int   cyc_len;
        int   low_len;
        txn_t held;
        txn_t cur;
        cyc_prev = 1'b0;
        cyc_len  = 0;
        low_len  = 999;
        held     = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cyc_prev = 1'b0;
                cyc_len  = 0;
                low_len  = 999;
            end else begin
                if (bus.o_rsp_valid) rsp_q.push_back({bus.o_rsp_we, bus.o_rsp_err, bus.o_rsp_data});
                if (bus.o_wb_stb !== bus.o_wb_cyc) stab_viol++;
                if (bus.o_wb_cyc) begin
                    cur = {bus.o_wb_we, bus.o_wb_adr, bus.o_wb_dat, bus.o_wb_sel};
                    if (!cyc_prev) begin
                        bus_q.push_back(cur);
                        gap_q.push_back(low_len);
                        held    = cur;
                        cyc_len = 0;
                    end else if (cur !== held) begin
                        stab_viol++;
                    end
                    cyc_len++;
                end else begin
                    if (cyc_prev) begin
                        len_q.push_back(cyc_len);
                        low_len = 0;
                    end
                    low_len++;
                end
                cyc_prev = bus.o_wb_cyc;
            end
        end
    end

    function automatic rsp_t model_rsp(txn_t t, int mode);
        rsp_t r;
        r.we   = t.we;
        r.err  = (mode != 0);
        r.data = (mode == 0 && !t.we) ? (t.adr ^ rd_key) : 32'h0;
        return r;
    endfunction

    task automatic clear_queues();
        bus_q.delete();
        exp_txn_q.delete();
        rsp_q.delete();
        exp_rsp_q.delete();
        len_q.delete();
        exp_len_q.delete();
        gap_q.delete();
        mode_q.delete();
        lat_q.delete();
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the request
    task automatic push_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int mode, input int lat,
                            output int stalls);
        txn_t t;
        t = {we, adr, (we ? dat : 32'h0), sel};
        mode_q.push_back(mode);
        lat_q.push_back(lat);
        exp_txn_q.push_back(t);
        exp_rsp_q.push_back(model_rsp(t, mode));
        exp_len_q.push_back(mode == 3 ? TMO : lat + 1);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = we;
        bus.i_req_addr  = adr;
        bus.i_req_data  = dat;
        bus.i_req_sel   = sel;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (bus.o_req_ready) break;
            stalls++;
            if (stalls > 200) begin
                total++;
                bad++;
                $display("[TB] FAIL push_accept: got ready=0 for %0d cycles, want acceptance", stalls);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int g;
        g = 0;
        while (rsp_q.size() < n && g < 600) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_adr, bus.o_wb_dat, bus.o_wb_sel} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_wb: got adr=%h dat=%h sel=%h we/cyc/stb=%b%b%b, want all 0",
                     bus.o_wb_adr, bus.o_wb_dat, bus.o_wb_sel, bus.o_wb_we, bus.o_wb_cyc, bus.o_wb_stb);
        end
        total++;
        if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_we, bus.o_rsp_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_rsp: got v/e/w=%b%b%b data=%h, want all 0",
                     bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_we, bus.o_rsp_data);
        end
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_flags: got busy=%b ready=%b, want busy=0 ready=1", bus.o_busy, bus.o_req_ready);
        end
        @(posedge clk);
        #2 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        int   st;
        rsp_t want;
        clear_queues();
        rd_key = 32'hDEADBEEF ^ 32'h0000_0100;
        want   = {1'b0, 1'b0, 32'hDEADBEEF};
        push_req(1'b0, 32'h100, 32'h1234_5678, 4'hF, 0, 0, st);
        wait_drain(1);
        total++;
        if (rsp_q.size() != 1) begin
            bad++;
            $display("[TB] FAIL read_count: got %0d responses, want 1", rsp_q.size());
        end
        total++;
        if (rsp_q.size() < 1 || rsp_q[0] !== want) begin
            bad++;
            $display("[TB] FAIL read_rsp: got %h, want %h", (rsp_q.size() > 0) ? rsp_q[0] : '0, want);
        end
        total++;
        if (bus_q.size() < 1 || bus_q[0] !== txn_t'({1'b0, 32'h100, 32'h0, 4'hF})) begin
            bad++;
            $display("[TB] FAIL read_bus: got %h, want adr=100 dat=0 sel=f we=0", (bus_q.size() > 0) ? bus_q[0] : '0);
        end
        total++;
        if (len_q.size() < 1 || len_q[0] != 1) begin
            bad++;
            $display("[TB] FAIL read_cyc_len: got %0d, want 1", (len_q.size() > 0) ? len_q[0] : -1);
        end
        total++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_data !== 32'hDEADBEEF || bus.o_rsp_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_hold: got v=%b data=%h err=%b, want v=0 data=deadbeef err=0",
                     bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        int first_stall;
        clear_queues();
        first_stall = -1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            push_req(1'b1, 32'h2000 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)), 0, 3, st);
            if (st > 0 && first_stall < 0) first_stall = i;
        end
        wait_drain(6);
        // The first request leaves for the bus at once, so DEPTH more fill the FIFO
        total++;
        if (first_stall != DEPTH + 1) begin
            bad++;
            $display("[TB] FAIL b2b_ready_drop: got first stall at push %0d, want %0d", first_stall, DEPTH + 1);
        end
        total++;
        if (bus_q.size() != 6 || rsp_q.size() != 6 || gap_q.size() != 6) begin
            bad++;
            $display("[TB] FAIL b2b_counts: got bus=%0d rsp=%0d gaps=%0d, want 6 each", bus_q.size(), rsp_q.size(), gap_q.size());
        end
        for (int i = 0; i < bus_q.size() && i < exp_txn_q.size(); i++) begin
            total++;
            if (bus_q[i] !== exp_txn_q[i]) begin
                bad++;
                $display("[TB] FAIL b2b_bus[%0d]: got %h, want %h", i, bus_q[i], exp_txn_q[i]);
            end
        end
        for (int i = 0; i < rsp_q.size() && i < exp_rsp_q.size(); i++) begin
            total++;
            if (rsp_q[i] !== exp_rsp_q[i]) begin
                bad++;
                $display("[TB] FAIL b2b_rsp[%0d]: got %h, want %h", i, rsp_q[i], exp_rsp_q[i]);
            end
        end
        for (int i = 1; i < gap_q.size(); i++) begin
            total++;
            if (gap_q[i] != 1) begin
                bad++;
                $display("[TB] FAIL b2b_gap[%0d]: got %0d low cycles, want 1", i, gap_q[i]);
            end
        end
    endtask

    task automatic test_err_ack();
        int st;
        clear_queues();
        rd_key = 32'h5A5A_0F0F;
        @(posedge clk);
        #1;
        push_req(1'b0, 32'h300, 32'h0, 4'hF, 2, 1, st);
        push_req(1'b0, 32'h304, 32'h0, 4'h3, 0, 0, st);
        wait_drain(2);
        total++;
        if (rsp_q.size() != 2) begin
            bad++;
            $display("[TB] FAIL errack_count: got %0d responses, want 2", rsp_q.size());
        end
        total++;
        if (rsp_q.size() < 1 || rsp_q[0] !== rsp_t'({1'b0, 1'b1, 32'h0})) begin
            bad++;
            $display("[TB] FAIL errack_rsp0: got %h, want we=0 err=1 data=0", (rsp_q.size() > 0) ? rsp_q[0] : '0);
        end
        total++;
        if (rsp_q.size() < 2 || rsp_q[1] !== exp_rsp_q[1]) begin
            bad++;
            $display("[TB] FAIL errack_rsp1: got %h, want %h", (rsp_q.size() > 1) ? rsp_q[1] : '0, exp_rsp_q[1]);
        end
        total++;
        if (bus_q.size() < 2 || bus_q[1] !== exp_txn_q[1]) begin
            bad++;
            $display("[TB] FAIL errack_bus1: got %h, want %h", (bus_q.size() > 1) ? bus_q[1] : '0, exp_txn_q[1]);
        end
    endtask

    task automatic test_timeout();
        int st;
        clear_queues();
        @(posedge clk);
        #1;
        push_req(1'b0, 32'h400, 32'h0, 4'hF, 3, 0, st);
        wait_drain(1);
        total++;
        if (len_q.size() < 1 || len_q[0] != TMO) begin
            bad++;
            $display("[TB] FAIL tmo_len: got %0d cycles, want %0d", (len_q.size() > 0) ? len_q[0] : -1, TMO);
        end
        total++;
        if (rsp_q.size() != 1 || rsp_q[0] !== rsp_t'({1'b0, 1'b1, 32'h0})) begin
            bad++;
            $display("[TB] FAIL tmo_rsp: got %0d rsp first=%h, want 1 rsp we=0 err=1 data=0",
                     rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : '0);
        end
    endtask

    task automatic test_spurious_ack();
        int st;
        clear_queues();
        @(posedge clk);
        #1;
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (rsp_q.size() != 0 || bus_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL spur_quiet: got rsp=%0d cycles=%0d, want 0 and 0", rsp_q.size(), bus_q.size());
        end
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_wb_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL spur_state: got busy=%b ready=%b cyc=%b, want 0 1 0", bus.o_busy, bus.o_req_ready, bus.o_wb_cyc);
        end
        @(posedge clk);
        #1;
        push_req(1'b0, 32'h500, 32'h0, 4'hF, 0, 0, st);
        wait_drain(1);
        total++;
        if (rsp_q.size() != 1 || rsp_q[0] !== exp_rsp_q[0] || len_q.size() < 1 || len_q[0] != 1) begin
            bad++;
            $display("[TB] FAIL spur_after: got %0d rsp first=%h, want 1 rsp %h len 1",
                     rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : '0, exp_rsp_q[0]);
        end
    endtask

    task automatic test_random();
        int          st;
        logic [31:0] adr;
        clear_queues();
        stab_viol = 0;
        rd_key = $urandom;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            adr = $urandom & 32'hFFFF_FFFC;
            push_req(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(1, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 4), st);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain(16);
        total++;
        if (rsp_q.size() != 16 || bus_q.size() != 16 || len_q.size() != 16) begin
            bad++;
            $display("[TB] FAIL rnd_counts: got rsp=%0d bus=%0d len=%0d, want 16 each", rsp_q.size(), bus_q.size(), len_q.size());
        end
        for (int i = 0; i < rsp_q.size() && i < exp_rsp_q.size(); i++) begin
            total++;
            if (rsp_q[i] !== exp_rsp_q[i]) begin
                bad++;
                $display("[TB] FAIL rnd_rsp[%0d]: got %h, want %h", i, rsp_q[i], exp_rsp_q[i]);
            end
        end
        for (int i = 0; i < bus_q.size() && i < exp_txn_q.size(); i++) begin
            total++;
            if (bus_q[i] !== exp_txn_q[i] || i >= len_q.size() || len_q[i] != exp_len_q[i]) begin
                bad++;
                $display("[TB] FAIL rnd_bus[%0d]: got %h len %0d, want %h len %0d", i, bus_q[i],
                         (i < len_q.size()) ? len_q[i] : -1, exp_txn_q[i], exp_len_q[i]);
            end
        end
        total++;
        if (stab_viol != 0) begin
            bad++;
            $display("[TB] FAIL rnd_stable: got %0d unstable bus cycles, want 0", stab_viol);
        end
    endtask

    task automatic test_timeout_zero();
        int hold;
        hold = 0;
        @(posedge clk);
        #1;
        bus0.i_req_valid = 1'b1;
        bus0.i_req_we    = 1'b0;
        bus0.i_req_addr  = 32'h600;
        @(posedge clk);
        #1;
        bus0.i_req_valid = 1'b0;
        @(posedge clk);
        repeat (1000) begin
            @(negedge clk);
            if (bus0.o_wb_cyc && bus0.o_wb_stb && !bus0.o_rsp_valid) hold++;
        end
        total++;
        if (hold != 1000) begin
            bad++;
            $display("[TB] FAIL tmo0_hold: got cyc held %0d of 1000 cycles, want 1000", hold);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        clear_queues();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 32'h700 + 32'(4 * i), $urandom, 4'hF, 0, 40, st);
        end
        @(negedge clk);
        total++;
        if (bus.o_wb_cyc !== 1'b1 || bus.o_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_pre: got cyc=%b busy=%b, want 1 1", bus.o_wb_cyc, bus.o_busy);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_drop: got cyc=%b stb=%b, want 0 0", bus.o_wb_cyc, bus.o_wb_stb);
        end
        #3;
        clear_queues();
        rstn = 1'b1;
        #1;
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_flags: got busy=%b ready=%b, want 0 1", bus.o_busy, bus.o_req_ready);
        end
        repeat (40) @(negedge clk);
        total++;
        if (rsp_q.size() != 0 || bus_q.size() != 0 || bus.o_wb_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_silent: got rsp=%0d cycles=%0d cyc=%b, want 0 0 0", rsp_q.size(), bus_q.size(), bus.o_wb_cyc);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        spurious = 1'b0;
        rd_key   = '0;
        stab_viol = 0;
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_addr   = '0;
        bus.i_req_data   = '0;
        bus.i_req_sel    = '0;
        bus0.i_req_valid = 1'b0;
        bus0.i_req_we    = 1'b0;
        bus0.i_req_addr  = '0;
        bus0.i_req_data  = '0;
        bus0.i_req_sel   = 4'hF;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_err_ack();
        test_timeout();
        test_spurious_ack();
        test_random();
        test_timeout_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
